// File: rtl/player_sprite_drawer_pkg.sv
// Shared types and constants for the player sprite drawer and the object hit tester.
// The object state is the controller's 5-field record: {img_id, x, y, width, height}.
package player_sprite_drawer_pkg;

  localparam int COORD_W = 11;

  localparam int OBJ_IMG = 0;
  localparam int OBJ_X   = 1;
  localparam int OBJ_Y   = 2;
  localparam int OBJ_W   = 3;
  localparam int OBJ_H   = 4;

  localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;

  typedef logic [0:4][0:10] object_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] img_id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } obj_fields_t;

  // Fields are stored MSB-first ([0:10]), so a plain copy keeps numeric values intact.
  function automatic obj_fields_t unpack_state(input object_state_t s);
    obj_fields_t f;
    f.img_id = s[OBJ_IMG];
    f.x      = s[OBJ_X];
    f.y      = s[OBJ_Y];
    f.w      = s[OBJ_W];
    f.h      = s[OBJ_H];
    return f;
  endfunction

endpackage

// File: rtl/player_sprite_drawer_hit_test.sv
// Combinational box test of one pixel against an object rectangle, plus the
// pixel's position relative to the box origin for sprite ROM addressing.
module object_hit_test
  import player_sprite_drawer_pkg::*;
#(
  parameter int MAX_W = 64,
  parameter int MAX_H = 64,
  localparam int XW = $clog2(MAX_W),
  localparam int YW = $clog2(MAX_H)
) (
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] obj_w,
  input  logic [COORD_W-1:0] obj_h,
  output logic               hit,
  output logic [XW-1:0]      rel_x,
  output logic [YW-1:0]      rel_y
);

  logic [COORD_W-1:0] diff_x, diff_y;
  logic [COORD_W:0]   end_x, end_y;
  logic               in_x, in_y;

  always_comb begin
    diff_x = pixelX - obj_x;
    diff_y = pixelY - obj_y;
    // One extra bit so a box near the right/bottom edge cannot wrap past zero.
    end_x  = {1'b0, obj_x} + {1'b0, obj_w};
    end_y  = {1'b0, obj_y} + {1'b0, obj_h};
    in_x   = (pixelX >= obj_x) && ({1'b0, pixelX} < end_x) && (diff_x < COORD_W'(MAX_W));
    in_y   = (pixelY >= obj_y) && ({1'b0, pixelY} < end_y) && (diff_y < COORD_W'(MAX_H));
    hit    = pixel_valid && in_x && in_y;
    rel_x  = diff_x[XW-1:0];
    rel_y  = diff_y[YW-1:0];
  end

endmodule

// File: rtl/player_sprite_drawer.sv
// Per-pixel draw data for the player object: frame-latched shadow state, box hit test,
// sprite ROM addressing and transparent-colour keying at a fixed 3-cycle latency.
module player_sprite_drawer
  import player_sprite_drawer_pkg::*;
#(
  parameter int         MAX_W       = 64,
  parameter int         MAX_H       = 64,
  parameter int         ADDR_W      = 19,
  parameter logic [7:0] TRANSPARENT = TRANSPARENT_RGB
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                frame_start,
  input  object_state_t       object_state,
  input  logic [COORD_W-1:0]  pixelX,
  input  logic [COORD_W-1:0]  pixelY,
  input  logic                pixel_valid,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic                drawing_request,
  output logic [7:0]          rgb_out
);

  localparam int XW     = $clog2(MAX_W);
  localparam int YW     = $clog2(MAX_H);
  localparam int FULL_W = COORD_W + YW + XW;

  object_state_t      shadow;
  obj_fields_t        obj;
  logic               hit, hit1, hit2;
  logic [XW-1:0]      rel_x;
  logic [YW-1:0]      rel_y;
  logic [FULL_W-1:0]  addr_full;

  // Shadow copy taken once per frame; a pixel in the frame_start cycle still sees the old copy.
  // NOTE: all state uses non-blocking assignments and an async reset, so every register
  // updates from pre-edge values and clears the instant resetN falls.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) shadow <= '0;
    else if (frame_start) shadow <= object_state;
  end

  always_comb obj = unpack_state(shadow);

  object_hit_test #(
    .MAX_W(MAX_W),
    .MAX_H(MAX_H)
  ) u_hit_test (
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .pixel_valid (pixel_valid),
    .obj_x       (obj.x),
    .obj_y       (obj.y),
    .obj_w       (obj.w),
    .obj_h       (obj.h),
    .hit         (hit),
    .rel_x       (rel_x),
    .rel_y       (rel_y)
  );

  // Power-of-2 slot and stride make img_id*MAX_W*MAX_H + rel_y*MAX_W + rel_x a plain concat.
  always_comb addr_full = {obj.img_id, rel_y, rel_x};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit1            <= 1'b0;
      hit2            <= 1'b0;
      rom_addr        <= '0;
      drawing_request <= 1'b0;
      rgb_out         <= '0;
    end else begin
      hit1 <= hit;
      if (hit) rom_addr <= ADDR_W'(addr_full);
      hit2            <= hit1;
      drawing_request <= hit2 && (rom_data != TRANSPARENT);
      rgb_out         <= rom_data;
    end
  end

endmodule

// File: tb/tb_player_sprite_drawer.sv
// Directed bench for player_sprite_drawer: a vector table of single pixels pushed
// through the 3-stage pipe, plus sequences for frame latching, throughput and reset.
module tb_player_sprite_drawer;
  import player_sprite_drawer_pkg::*;

  logic          clk = 1'b0;
  logic          resetN;
  logic          frame_start;
  object_state_t object_state;
  logic [10:0]   pixelX, pixelY;
  logic          pixel_valid;
  logic [18:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          drawing_request;
  logic [7:0]    rgb_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] last_addr = '0;

  player_sprite_drawer dut (
    .clk             (clk),
    .resetN          (resetN),
    .frame_start     (frame_start),
    .object_state    (object_state),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .pixel_valid     (pixel_valid),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .drawing_request (drawing_request),
    .rgb_out         (rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          load;
    int          img, x, y, w, h;
    logic [10:0] px, py;
    logic        pv;
    logic [7:0]  rd;
    logic        exp_hit;
    logic [18:0] exp_addr;
    logic        exp_dr;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string name, bit load, int img, int x, int y, int w, int h,
                              int px, int py, bit pv, logic [7:0] rd,
                              bit exp_hit, int exp_addr, bit exp_dr);
    vec_t v;
    v.name = name; v.load = load;
    v.img = img; v.x = x; v.y = y; v.w = w; v.h = h;
    v.px = 11'(px); v.py = 11'(py); v.pv = pv; v.rd = rd;
    v.exp_hit = exp_hit; v.exp_addr = 19'(exp_addr); v.exp_dr = exp_dr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic set_state(input int img, input int x, input int y, input int w, input int h);
    object_state[OBJ_IMG] = 11'(img);
    object_state[OBJ_X]   = 11'(x);
    object_state[OBJ_Y]   = 11'(y);
    object_state[OBJ_W]   = 11'(w);
    object_state[OBJ_H]   = 11'(h);
  endtask

  task automatic load_state(input int img, input int x, input int y, input int w, input int h);
    @(negedge clk);
    set_state(img, x, y, w, h);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // One isolated pixel through the pipe; ROM data is supplied in the N+2 slot.
  task automatic apply_pixel(input string name, input logic [10:0] px, input logic [10:0] py,
                             input logic pv, input logic fs, input logic [7:0] rd,
                             input logic exp_hit, input logic [18:0] exp_addr, input logic exp_dr);
    @(negedge clk);
    pixelX = px; pixelY = py; pixel_valid = pv; frame_start = fs; rom_data = 8'h00;
    @(posedge clk); #1;
    if (exp_hit) last_addr = exp_addr;
    check({name, "/rom_addr"}, 32'(rom_addr), 32'(last_addr));
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; rom_data = rd;
    @(posedge clk); #1;
    check({name, "/early_draw"}, 32'(drawing_request), 32'd0);
    @(posedge clk); #1;
    check({name, "/drawing_request"}, 32'(drawing_request), 32'(exp_dr));
    if (exp_dr) check({name, "/rgb_out"}, 32'(rgb_out), 32'(rd));
  endtask

  logic [7:0] tp_data [3];
  logic       tp_dr   [3];

  initial begin
    resetN = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    pixelX = '0; pixelY = '0; rom_data = '0; object_state = '0;

    // Origin box from the controller, then edges, keying, slots and size limits.
    vecs[0]  = mk("reset_shadow", 0, 0, 0, 0, 0, 0,      0,   0, 1, 8'h1C, 0, 0, 0);
    vecs[1]  = mk("basic_hit",    1, 0, 256, 380, 32, 36, 256, 380, 1, 8'h1C, 1, 0, 1);
    vecs[2]  = mk("edge_br",      0, 0, 0, 0, 0, 0,      287, 415, 1, 8'h3A, 1, 35*64+31, 1);
    vecs[3]  = mk("right_out",    0, 0, 0, 0, 0, 0,      288, 380, 1, 8'h1C, 0, 0, 0);
    vecs[4]  = mk("left_out",     0, 0, 0, 0, 0, 0,      255, 380, 1, 8'h1C, 0, 0, 0);
    vecs[5]  = mk("bottom_out",   0, 0, 0, 0, 0, 0,      256, 416, 1, 8'h1C, 0, 0, 0);
    vecs[6]  = mk("transparent",  0, 0, 0, 0, 0, 0,      260, 390, 1, 8'hFF, 1, 10*64+4, 0);
    vecs[7]  = mk("pixel_invalid",0, 0, 0, 0, 0, 0,      260, 390, 0, 8'h1C, 0, 0, 0);
    // 99*4096 + 2*64 + 1 = 405504 + 129
    vecs[8]  = mk("img99",        1, 99, 256, 380, 32, 36, 257, 382, 1, 8'hE0, 1, 405633, 1);
    vecs[9]  = mk("maxw_edge",    1, 0, 0, 0, 100, 10,   63,   9, 1, 8'h07, 1, 9*64+63, 1);
    vecs[10] = mk("maxw_out",     0, 0, 0, 0, 0, 0,      64,   0, 1, 8'h07, 0, 0, 0);
    vecs[11] = mk("no_wrap",      1, 5, 2040, 0, 20, 10, 2045, 3, 1, 8'h44, 1, 5*4096+3*64+5, 1);

    // Reset state
    #12;
    check("reset/rom_addr", 32'(rom_addr), 32'd0);
    check("reset/drawing_request", 32'(drawing_request), 32'd0);
    check("reset/rgb_out", 32'(rgb_out), 32'd0);
    @(negedge clk); resetN = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].load) load_state(vecs[i].img, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
      apply_pixel(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].pv, 1'b0, vecs[i].rd,
                  vecs[i].exp_hit, vecs[i].exp_addr, vecs[i].exp_dr);
    end

    // Zero width never hits, even at the box origin.
    load_state(0, 256, 380, 0, 36);
    apply_pixel("zero_w", 11'd256, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b0, '0, 1'b0);

    // Frame latch: a state change without frame_start is ignored.
    load_state(0, 256, 380, 32, 36);
    @(negedge clk); set_state(0, 300, 380, 32, 36);
    apply_pixel("latch_old", 11'd256, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b1, 19'd0, 1'b1);
    load_state(0, 300, 380, 32, 36);
    apply_pixel("latch_new_out", 11'd256, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b0, '0, 1'b0);
    apply_pixel("latch_new_in", 11'd301, 11'd381, 1'b1, 1'b0, 8'h1C, 1'b1, 19'd65, 1'b1);

    // frame_start coincident with a valid pixel: that pixel uses the old shadow.
    @(negedge clk); set_state(0, 256, 380, 32, 36);
    apply_pixel("coincident_old", 11'd302, 11'd380, 1'b1, 1'b1, 8'h1C, 1'b1, 19'd2, 1'b1);
    apply_pixel("coincident_new", 11'd302, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b0, '0, 1'b0);

    // Back-to-back pixels, one per cycle, with ROM data following each by two cycles.
    tp_data[0] = 8'h1C; tp_data[1] = 8'hFF; tp_data[2] = 8'h03;
    tp_dr[0]   = 1'b1;  tp_dr[1]   = 1'b0;  tp_dr[2]   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pixelX = 11'(256 + c); pixelY = 11'd380; pixel_valid = (c < 3);
      rom_data = (c >= 2) ? tp_data[c-2] : 8'h00;
      @(posedge clk); #1;
      if (c < 3) begin
        last_addr = 19'(c);
        check($sformatf("stream%0d/rom_addr", c), 32'(rom_addr), 32'(c));
      end
      if (c >= 2) begin
        check($sformatf("stream%0d/drawing_request", c-2), 32'(drawing_request), 32'(tp_dr[c-2]));
        if (tp_dr[c-2]) check($sformatf("stream%0d/rgb_out", c-2), 32'(rgb_out), 32'(tp_data[c-2]));
      end
    end

    // Async reset with a drawing pixel in flight.
    @(negedge clk);
    pixelX = 11'd260; pixelY = 11'd390; pixel_valid = 1'b1; rom_data = 8'h00;
    @(posedge clk); #1;
    check("midreset/rom_addr_before", 32'(rom_addr), 32'(10*64+4));
    @(negedge clk); pixel_valid = 1'b0; rom_data = 8'h1C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset/draw_before", 32'(drawing_request), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("midreset/rom_addr", 32'(rom_addr), 32'd0);
    check("midreset/drawing_request", 32'(drawing_request), 32'd0);
    check("midreset/rgb_out", 32'(rgb_out), 32'd0);
    @(negedge clk); resetN = 1'b1; last_addr = '0;
    apply_pixel("after_reset", 11'd256, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b0, '0, 1'b0);
    load_state(0, 256, 380, 32, 36);
    apply_pixel("after_reload", 11'd257, 11'd380, 1'b1, 1'b0, 8'h1C, 1'b1, 19'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
